hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 12 +
 rtl/hazard_reg_counter.sv | 39 +++
 rtl/hazard_scoreboard.sv | 84 ++++++++
 tb/tb_hazard_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults for the register hazard scoreboard: geometry, latency range
// and the width of the stall-cycle statistics counter.
package hazard_pkg;

   localparam int NREG_DEF    = 8;
   localparam int NSRC_DEF    = 3;
   localparam int MAX_LAT_DEF = 4;
   localparam int STALL_CNT_W = 16;

   localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register result countdown: loads the issue latency when the register is
// claimed as a destination, then counts down to zero (not busy).
module hazard_reg_counter #(
   parameter int LW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [LW-1:0] lat_i,
   output logic          busy_o
);

   logic [LW-1:0] cnt_q, cnt_d;

   // A load only happens when the counter is already idle (the WAW check
   // stalls otherwise), so load simply takes priority over decrement.
   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = lat_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - LW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue hazard scoreboard: RAW/WAW interlock on pending results,
// one-bubble-per-cycle stall generation and a saturating stall statistic.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter  int NREG     = NREG_DEF,
   parameter  int NSRC     = NSRC_DEF,
   parameter  int MAX_LAT  = MAX_LAT_DEF,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG),
   localparam int LW       = $clog2(MAX_LAT + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue_valid,
   input  logic [NSRC*AW-1:0]     issue_src,
   input  logic [NSRC-1:0]        issue_src_en,
   input  logic                   issue_we,
   input  logic [AW-1:0]          issue_rd,
   input  logic [LW-1:0]          issue_lat,
   input  logic                   flush,
   output logic                   stall,
   output logic                   issue_accept,
   output logic [NREG-1:0]        busy_vec,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   logic                   hazard;
   logic [LW-1:0]          lat_clamped;
   logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   // RAW on any read source, or WAW on the destination; busy_vec reflects the
   // counters before the edge, so a result is usable the cycle its count hits 0.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (issue_src_en[i] && busy_vec[issue_src[i*AW +: AW]]) begin
            hazard = 1'b1;
         end
      end
      if (issue_we && busy_vec[issue_rd]) begin
         hazard = 1'b1;
      end
   end

   assign stall        = issue_valid & ~flush & hazard;
   assign issue_accept = issue_valid & ~flush & ~hazard;

   assign lat_clamped = (int'(issue_lat) > MAX_LAT) ? LW'(MAX_LAT) : issue_lat;

   for (genvar r = 0; r < NREG; r++) begin : g_reg
      if (ZERO_REG != 0 && r == 0) begin : g_zero
         assign busy_vec[r] = 1'b0;
      end else begin : g_cnt
         hazard_reg_counter #(
            .LW(LW)
         ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .load_i(issue_accept && issue_we && (issue_rd == AW'(r))),
            .lat_i (lat_clamped),
            .busy_o(busy_vec[r])
         );
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && stall_cycles_q != STALL_CNT_MAX) begin
         stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a cycle-stamped readiness model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hazard_scoreboard;

   localparam int NREG     = 8;
   localparam int NSRC     = 3;
   localparam int MAX_LAT  = 4;
   localparam int ZERO_REG = 1;
   localparam int AW       = 3;
   localparam int LW       = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic                issue_valid;
   logic [NSRC*AW-1:0]  issue_src;
   logic [NSRC-1:0]     issue_src_en;
   logic                issue_we;
   logic [AW-1:0]       issue_rd;
   logic [LW-1:0]       issue_lat;
   logic                flush;
   logic                stall;
   logic                issue_accept;
   logic [NREG-1:0]     busy_vec;
   logic [15:0]         stall_cycles;

   int n_checks = 0;
   int n_errors = 0;

   // Model: register r is busy while the current cycle number is below the
   // cycle at which its result becomes forwardable.
   int cyc = 0;
   int ready_at [NREG];
   int exp_sc = 0;
   logic exp_stall, exp_acc;
   logic [NREG-1:0] exp_bv;

   hazard_scoreboard #(
      .NREG(NREG), .NSRC(NSRC), .MAX_LAT(MAX_LAT), .ZERO_REG(ZERO_REG)
   ) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_src(issue_src),
      .issue_src_en(issue_src_en), .issue_we(issue_we), .issue_rd(issue_rd),
      .issue_lat(issue_lat), .flush(flush), .stall(stall),
      .issue_accept(issue_accept), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic busy_m(input int r);
      if (ZERO_REG != 0 && r == 0) return 1'b0;
      return cyc < ready_at[r];
   endfunction

   task automatic model_clear();
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      exp_sc = 0;
   endtask

   // Per-cycle compare at the falling edge, model advance at the rising edge.
   initial begin
      model_clear();
      forever begin
         @(negedge clk);
         if (reset) model_clear();
         exp_stall = 1'b0;
         if (issue_valid && !flush) begin
            for (int i = 0; i < NSRC; i++)
               if (issue_src_en[i] && busy_m(int'(issue_src[i*AW +: AW]))) exp_stall = 1'b1;
            if (issue_we && busy_m(int'(issue_rd))) exp_stall = 1'b1;
         end
         exp_acc = issue_valid && !flush && !exp_stall;
         for (int r = 0; r < NREG; r++) exp_bv[r] = busy_m(r);
         check("stall", 32'(stall), 32'(exp_stall));
         check("issue_accept", 32'(issue_accept), 32'(exp_acc));
         check("busy_vec", 32'(busy_vec), 32'(exp_bv));
         check("stall_cycles", 32'(stall_cycles), 32'(exp_sc));
         @(posedge clk);
         if (reset) begin
            model_clear();
         end else begin
            if (exp_stall && exp_sc < 16'hFFFF) exp_sc++;
            if (exp_acc && issue_we && !(ZERO_REG != 0 && issue_rd == 0))
               ready_at[issue_rd] = cyc + 1 + ((int'(issue_lat) > MAX_LAT) ? MAX_LAT : int'(issue_lat));
         end
         cyc++;
      end
   end

   task automatic drive(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] en, input logic we,
                        input logic [2:0] rd, input logic [2:0] lat, input logic fl);
      issue_valid  = v;
      issue_src    = {s2, s1, s0};
      issue_src_en = en;
      issue_we     = we;
      issue_rd     = rd;
      issue_lat    = lat;
      flush        = fl;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 3'd0, 1'b0);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one instruction until accepted; returns the stall cycles seen.
   task automatic issue(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] en, input logic we, input logic [2:0] rd,
                        input logic [2:0] lat, output int stalls);
      bit done = 0;
      stalls = 0;
      drive(1'b1, s0, s1, s2, en, we, rd, lat, 1'b0);
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (issue_accept) done = 1;
         else stalls++;
         @(posedge clk);
         #1;
      end
      if (!done) check("issue_timeout", 32'd0, 32'd1);
      drive(1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 3'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st;
      reset = 1'b1;
      drive(1'b1, 3'd3, 3'd0, 3'd0, 3'b001, 1'b1, 3'd3, 3'd2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_accept", 32'(issue_accept), 32'd1);
      check("rst_busy", 32'(busy_vec), 32'd0);
      check("rst_sc", 32'(stall_cycles), 32'd0);
      reset = 1'b0;
      idle(2);

      // Load-use: one bubble.
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd3, 3'd1, st);
      check("lu_producer_stalls", 32'(st), 32'd0);
      issue(3'd3, 3'd0, 3'd0, 3'b001, 1'b0, 3'd0, 3'd0, st);
      check("lu_stalls", 32'(st), 32'd1);
      check("lu_sc", 32'(stall_cycles), 32'd1);
      idle(5);

      // Multi-cycle latency on slot 2.
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd5, 3'd4, st);
      check("mc_busy5", 32'(busy_vec), 32'h20);
      issue(3'd0, 3'd0, 3'd5, 3'b100, 1'b0, 3'd0, 3'd0, st);
      check("mc_stalls", 32'(st), 32'd4);
      check("mc_sc", 32'(stall_cycles), 32'd5);
      idle(5);

      // Zero latency: no bubble, slot 1 source.
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd1, 3'd0, st);
      issue(3'd0, 3'd1, 3'd0, 3'b010, 1'b0, 3'd0, 3'd0, st);
      check("lat0_stalls", 32'(st), 32'd0);
      idle(2);

      // WAW with clamped latency 7 -> 4.
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd2, 3'd7, st);
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd2, 3'd0, st);
      check("waw_stalls", 32'(st), 32'd4);
      idle(5);

      // Flush kills the dependent and counters keep running.
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd6, 3'd3, st);
      drive(1'b1, 3'd0, 3'd6, 3'd0, 3'b010, 1'b0, 3'd0, 3'd0, 1'b1);
      @(negedge clk);
      check("fl_stall", 32'(stall), 32'd0);
      check("fl_accept", 32'(issue_accept), 32'd0);
      check("fl_busy", 32'(busy_vec), 32'h40);
      @(posedge clk);
      #1;
      issue(3'd0, 3'd6, 3'd0, 3'b010, 1'b0, 3'd0, 3'd0, st);
      check("fl_after_stalls", 32'(st), 32'd2);
      idle(5);

      // Register 0 is never tracked.
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd0, 3'd3, st);
      check("z_busy", 32'(busy_vec), 32'd0);
      issue(3'd0, 3'd0, 3'd0, 3'b001, 1'b0, 3'd0, 3'd0, st);
      check("z_stalls", 32'(st), 32'd0);
      idle(2);

      // Reset mid-hazard discards everything.
      issue(3'd0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd4, 3'd4, st);
      idle(1);
      check("mr_busy_before", 32'(busy_vec), 32'h10);
      reset = 1'b1;
      #1;
      check("mr_busy", 32'(busy_vec), 32'd0);
      check("mr_sc", 32'(stall_cycles), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      issue(3'd4, 3'd0, 3'd0, 3'b001, 1'b0, 3'd0, 3'd0, st);
      check("mr_stalls", 32'(st), 32'd0);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
